// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that owns the single Common Data Bus.
// Define CDB_OUT_REG_EN to register the broadcast (latency 1); otherwise it is combinational.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W = 5,
  parameter int DATA_W = 32,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [IDX_W-1:0]            cdb_src,
  output logic [31:0]                 conflict_cnt
);

  // Returns {found, index} of the first valid requester at or after ptr, wrapping.
  function automatic logic [IDX_W:0] find_winner(input logic [NUM_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    int j;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      res = valid[j] ? {1'b1, IDX_W'(j)} : res;
    end
    return res;
  endfunction

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [31:0]        r_conflict_cnt;
  logic [IDX_W:0]     w_win;
  logic               w_grant_vld;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic [TAG_W-1:0]   w_tag;
  logic [DATA_W-1:0]  w_data;
  logic               w_conflict;

  assign w_win       = find_winner(req_valid, r_rr_ptr);
  assign w_grant_vld = w_win[IDX_W] & ~flush & ~rst;
  assign w_grant_idx = w_win[IDX_W-1:0];
  assign w_grant_oh  = w_grant_vld ? (NUM_REQ'(1) << w_grant_idx) : {NUM_REQ{1'b0}};
  assign req_ready   = w_grant_oh;
  // x & (x-1) is non-zero exactly when two or more bits are set.
  assign w_conflict  = ~flush & ((req_valid & (req_valid - NUM_REQ'(1))) != {NUM_REQ{1'b0}});
  assign conflict_cnt = r_conflict_cnt;

  // One-hot AND-OR mux of the winning tag/data; zero when nothing is granted.
  always_comb begin
    w_tag  = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_tag  = w_tag  | ({TAG_W{w_grant_oh[i]}}  & req_tag[i*TAG_W +: TAG_W]);
      w_data = w_data | ({DATA_W{w_grant_oh[i]}} & req_data[i*DATA_W +: DATA_W]);
    end
  end

  // Round-robin pointer and saturating conflict counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr       <= '0;
      r_conflict_cnt <= 32'd0;
    end else begin
      if (w_grant_vld) begin
        r_rr_ptr <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? IDX_W'(0) : w_grant_idx + IDX_W'(1);
      end
      if (w_conflict && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
    end
  end

`ifdef CDB_OUT_REG_EN
  logic               r_cdb_valid;
  logic [TAG_W-1:0]   r_cdb_tag;
  logic [DATA_W-1:0]  r_cdb_data;
  logic [IDX_W-1:0]   r_cdb_src;

  // Registered broadcast; payload holds its last value while valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
    end else begin
      r_cdb_valid <= w_grant_vld;
      if (w_grant_vld) begin
        r_cdb_tag  <= w_tag;
        r_cdb_data <= w_data;
        r_cdb_src  <= w_grant_idx;
      end
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_data  = r_cdb_data;
  assign cdb_src   = r_cdb_src;
`else
  assign cdb_valid = w_grant_vld;
  assign cdb_tag   = w_tag;
  assign cdb_data  = w_data;
  assign cdb_src   = w_grant_vld ? w_grant_idx : IDX_W'(0);
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter in its default (combinational broadcast) build.
module tb_cdb_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TAG_W = 5;
  localparam int DATA_W = 32;

  logic                      clk;
  logic                      rst;
  logic                      flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [1:0]                cdb_src;
  logic [31:0]               conflict_cnt;

  int n_vec;
  int n_err;

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled in the low phase.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] v, input logic f, input logic r);
    req_valid = v;
    flush = f;
    rst = r;
    #1;
  endtask

  task automatic chk_grant(input string tag, input int idx);
    logic [3:0] exp_oh;
    exp_oh = 4'b0001 << idx;
    chk({tag, "_ready"}, 64'(req_ready), 64'(exp_oh));
    chk({tag, "_valid"}, 64'(cdb_valid), 64'd1);
    chk({tag, "_src"},   64'(cdb_src),   64'(idx));
    chk({tag, "_tag"},   64'(cdb_tag),   64'(5'd16 + 5'(idx)));
    chk({tag, "_data"},  64'(cdb_data),  64'(32'hC0DE_0000 | 32'(idx)));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_valid"}, 64'(cdb_valid), 64'd0);
    chk({tag, "_tag"},   64'(cdb_tag),   64'd0);
    chk({tag, "_data"},  64'(cdb_data),  64'd0);
  endtask

  task automatic load_default_payload();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_tag[i*TAG_W +: TAG_W]    = 5'd16 + 5'(i);
      req_data[i*DATA_W +: DATA_W] = 32'hC0DE_0000 | 32'(i);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    load_default_payload();
    rst = 1'b1;
    flush = 1'b0;
    req_valid = 4'hF;
    @(negedge clk);

    // Reset held two cycles with every port requesting.
    for (int c = 0; c < 2; c++) begin
      drive(4'hF, 1'b0, 1'b1);
      chk_idle("rst");
      tick();
      chk("rst_cnt", 64'(conflict_cnt), 64'd0);
    end

    // Round robin from port 0 with all four ports valid.
    for (int k = 0; k < 8; k++) begin
      drive(4'hF, 1'b0, 1'b0);
      chk_grant("rr", k % 4);
      tick();
    end
    chk("rr_cnt", 64'(conflict_cnt), 64'd8);

    // Single requester on port 2 with a distinct payload.
    req_tag[2*TAG_W +: TAG_W]    = 5'd7;
    req_data[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    drive(4'b0100, 1'b0, 1'b0);
    chk("single_ready", 64'(req_ready), 64'h4);
    chk("single_valid", 64'(cdb_valid), 64'd1);
    chk("single_tag",   64'(cdb_tag),   64'd7);
    chk("single_data",  64'(cdb_data),  64'hDEAD_BEEF);
    chk("single_src",   64'(cdb_src),   64'd2);
    tick();
    chk("single_cnt", 64'(conflict_cnt), 64'd8);
    load_default_payload();

    // Pointer now at 3: invalid port 3 is skipped, wrap to 0 then 1.
    drive(4'b0011, 1'b0, 1'b0);
    chk_grant("wrap0", 0);
    tick();
    drive(4'b0011, 1'b0, 1'b0);
    chk_grant("wrap1", 1);
    tick();
    chk("wrap_cnt", 64'(conflict_cnt), 64'd10);

    // Flush blocks grant and counting; pointer (2) must be held.
    drive(4'hF, 1'b1, 1'b0);
    chk_idle("flush");
    tick();
    chk("flush_cnt", 64'(conflict_cnt), 64'd10);
    drive(4'hF, 1'b0, 1'b0);
    chk_grant("postflush", 2);
    tick();
    chk("postflush_cnt", 64'(conflict_cnt), 64'd11);

    // No requests: nothing granted, nothing counted, pointer stays at 3.
    drive(4'h0, 1'b0, 1'b0);
    chk_idle("none");
    tick();
    chk("none_cnt", 64'(conflict_cnt), 64'd11);
    drive(4'b1001, 1'b0, 1'b0);
    chk_grant("hold3", 3);
    tick();
    chk("hold3_cnt", 64'(conflict_cnt), 64'd12);

    // Reset mid-operation beats flush and requests, clears pointer and counter.
    drive(4'hF, 1'b1, 1'b1);
    chk_idle("midrst");
    tick();
    chk("midrst_cnt", 64'(conflict_cnt), 64'd0);
    drive(4'hF, 1'b0, 1'b0);
    chk_grant("after_rst", 0);
    tick();
    chk("after_rst_cnt", 64'(conflict_cnt), 64'd1);

    // Saturation: preload the counter one below all-ones.
    drive(4'h0, 1'b0, 1'b0);
    force dut.r_conflict_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.r_conflict_cnt;
    #1;
    chk("sat_preload", 64'(conflict_cnt), 64'hFFFF_FFFE);
    for (int c = 0; c < 3; c++) begin
      drive(4'b0110, 1'b0, 1'b0);
      tick();
      chk("sat_cnt", 64'(conflict_cnt), 64'hFFFF_FFFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case the clocked sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
